// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - request/response bundle for the shared multiplier
interface mult_share_arbiter_if #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2
) ();
    localparam int ID_W  = $clog2(N_REQ);
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int P_W   = A_WIDTH + B_WIDTH;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*A_WIDTH-1:0] req_a;
    logic [N_REQ*B_WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [P_W-1:0]           rsp_product;
    logic [INF_W-1:0]         inflight;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_product,
        input  inflight
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_product,
        output inflight
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter feeding one shared pipelined multiplier
module mult_share_arbiter #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_share_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int P_W   = A_WIDTH + B_WIDTH;
    localparam logic [ID_W:0] N_REQ_W = (ID_W + 1)'(N_REQ);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_nxt;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [N_REQ-1:0]   ready;
    logic               advance;
    logic               xfer;
    logic               consume;
    logic [A_WIDTH-1:0] a_sel;
    logic [B_WIDTH-1:0] b_sel;
    logic [P_W-1:0]     prod;

    logic [LATENCY-1:0] stg_valid;
    logic [ID_W-1:0]    stg_id   [LATENCY];
    logic [P_W-1:0]     stg_prod [LATENCY];
    logic [INF_W-1:0]   inflight_q;

    // The whole pipeline moves as one; it only stalls on an unconsumed result.
    assign advance = !stg_valid[LATENCY-1] || bus.rsp_ready;
    assign consume = stg_valid[LATENCY-1] && bus.rsp_ready;

    always_comb begin
        logic [ID_W:0] sum;
        sum       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= N_REQ_W) begin
                sum = sum - N_REQ_W;
            end
            if (!grant_any && bus.req_valid[sum[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        logic [ID_W:0] nsum;
        nsum = {1'b0, grant_idx} + (ID_W + 1)'(1);
        if (nsum >= N_REQ_W) begin
            nsum = '0;
        end
        ptr_nxt = nsum[ID_W-1:0];
    end

    // Reset gating keeps req_ready low while rst_n is held, even with requests pending.
    always_comb begin
        ready = '0;
        if (rst_n && advance && grant_any) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |(bus.req_valid & ready);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                a_sel = bus.req_a[k*A_WIDTH +: A_WIDTH];
                b_sel = bus.req_b[k*B_WIDTH +: B_WIDTH];
            end
        end
    end

    assign prod = {{B_WIDTH{1'b0}}, a_sel} * {{A_WIDTH{1'b0}}, b_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_id[i]   <= '0;
                stg_prod[i] <= '0;
            end
        end else if (advance) begin
            stg_valid[0] <= xfer;
            if (xfer) begin
                stg_id[0]   <= grant_idx;
                stg_prod[0] <= prod;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_id[i]    <= stg_id[i-1];
                stg_prod[i]  <= stg_prod[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            inflight_q <= '0;
        end else begin
            if (xfer) begin
                ptr <= ptr_nxt;
            end
            case ({xfer, consume})
                2'b10:   inflight_q <= inflight_q + INF_W'(1);
                2'b01:   inflight_q <= inflight_q - INF_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = stg_valid[LATENCY-1];
    assign bus.rsp_id      = stg_id[LATENCY-1];
    assign bus.rsp_product = stg_prod[LATENCY-1];
    assign bus.inflight    = inflight_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mult_share_arbiter_if #(.A_WIDTH(8), .B_WIDTH(8), .N_REQ(4), .LATENCY(2)) bus ();
    mult_share_arbiter_if #(.A_WIDTH(8), .B_WIDTH(8), .N_REQ(2), .LATENCY(1)) bus2 ();

    mult_share_arbiter #(.A_WIDTH(8), .B_WIDTH(8), .N_REQ(4), .LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mult_share_arbiter #(.A_WIDTH(8), .B_WIDTH(8), .N_REQ(2), .LATENCY(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // products of the fixed round-robin operands, worked by hand
    logic [15:0] rr_prod [4];
    logic [15:0] d2_prod [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.rsp_ready  = 1'b1;
        bus2.req_valid = '0;
        bus2.rsp_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        int r;
        bit stall;
        logic [3:0] exp_ready;

        rr_prod[0] = 16'h03A8;
        rr_prod[1] = 16'h01FE;
        rr_prod[2] = 16'h4000;
        rr_prod[3] = 16'h0E10;
        d2_prod[0] = 16'h000F;
        d2_prod[1] = 16'h07D0;

        rst_n          = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_valid  = 4'hF;
        bus.rsp_ready  = 1'b1;
        bus2.req_a     = '0;
        bus2.req_b     = '0;
        bus2.req_valid = '0;
        bus2.rsp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_inflight", 32'(bus.inflight), 32'h0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("rst_rsp_product", 32'(bus.rsp_product), 32'h0);
        do_reset();

        // single request FF*FF
        next_cycle();
        set_op(0, 8'hFF, 8'hFF);
        bus.req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        chk("single_rv0", 32'(bus.rsp_valid), 32'h0);
        next_cycle();
        bus.req_valid = 4'b0000;
        #1;
        chk("single_infl1", 32'(bus.inflight), 32'h1);
        chk("single_rv1", 32'(bus.rsp_valid), 32'h0);
        next_cycle();
        #1;
        chk("single_rv2", 32'(bus.rsp_valid), 32'h1);
        chk("single_id", 32'(bus.rsp_id), 32'h0);
        chk("single_prod", 32'(bus.rsp_product), 32'hFE01);
        chk("single_infl2", 32'(bus.inflight), 32'h1);
        next_cycle();
        #1;
        chk("single_rv3", 32'(bus.rsp_valid), 32'h0);
        chk("single_infl3", 32'(bus.inflight), 32'h0);

        // round robin with a 5-cycle stall in phases 8..12
        do_reset();
        set_op(0, 8'h12, 8'h34);
        set_op(1, 8'hFF, 8'h02);
        set_op(2, 8'h80, 8'h80);
        set_op(3, 8'h0F, 8'hF0);
        for (int p = 0; p < 17; p++) begin
            next_cycle();
            stall         = (p >= 8 && p <= 12);
            bus.rsp_ready = !stall;
            bus.req_valid = 4'hF;
            #1;
            g = (p <= 8) ? p : ((p <= 12) ? 8 : p - 5);
            r = (p <= 8) ? p - 2 : ((p <= 12) ? 6 : p - 7);
            exp_ready = stall ? 4'b0000 : (4'b0001 << (g % 4));
            chk($sformatf("rr_ready_p%0d", p), 32'(bus.req_ready), 32'(exp_ready));
            chk($sformatf("rr_rv_p%0d", p), 32'(bus.rsp_valid), (p >= 2) ? 32'h1 : 32'h0);
            chk($sformatf("rr_infl_p%0d", p), 32'(bus.inflight),
                (p == 0) ? 32'h0 : ((p == 1) ? 32'h1 : 32'h2));
            if (p >= 2) begin
                chk($sformatf("rr_id_p%0d", p), 32'(bus.rsp_id), 32'(r % 4));
                chk($sformatf("rr_prod_p%0d", p), 32'(bus.rsp_product), 32'(rr_prod[r % 4]));
            end
        end

        // pointer wrap/skip, zero operands, withdrawn request
        do_reset();
        next_cycle();
        set_op(2, 8'h0B, 8'h0D);
        bus.req_valid = 4'b0100;
        #1;
        chk("ptr_grant2", 32'(bus.req_ready), 32'h4);
        next_cycle();
        set_op(1, 8'h37, 8'h00);
        bus.req_valid = 4'b0010;
        #1;
        chk("ptr_grant1", 32'(bus.req_ready), 32'h2);
        next_cycle();
        set_op(2, 8'h00, 8'h55);
        bus.req_valid = 4'b0101;
        #1;
        chk("ptr_grant2b", 32'(bus.req_ready), 32'h4);
        chk("ptr_id_p2", 32'(bus.rsp_id), 32'h2);
        chk("ptr_prod_p2", 32'(bus.rsp_product), 32'h008F);
        next_cycle();
        bus.req_valid = 4'b0000;
        #1;
        chk("bzero_rv", 32'(bus.rsp_valid), 32'h1);
        chk("bzero_id", 32'(bus.rsp_id), 32'h1);
        chk("bzero_prod", 32'(bus.rsp_product), 32'h0);
        chk("ptr_infl_p3", 32'(bus.inflight), 32'h2);
        next_cycle();
        #1;
        chk("azero_id", 32'(bus.rsp_id), 32'h2);
        chk("azero_prod", 32'(bus.rsp_product), 32'h0);
        chk("ptr_infl_p4", 32'(bus.inflight), 32'h1);
        next_cycle();
        bus.req_valid = 4'b1001;
        #1;
        chk("wd_grant3", 32'(bus.req_ready), 32'h8);
        chk("wd_rv", 32'(bus.rsp_valid), 32'h0);
        bus.req_valid = 4'b0001;
        #1;
        chk("wd_grant0", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 4'b0000;
        #1;
        chk("wd_none", 32'(bus.req_ready), 32'h0);

        // reset while two results are in flight
        do_reset();
        for (int p = 0; p < 3; p++) begin
            next_cycle();
            bus.req_valid = 4'hF;
            #1;
            if (p < 2) begin
                chk($sformatf("mr_ready_p%0d", p), 32'(bus.req_ready), 32'(4'b0001 << p));
            end
        end
        chk("mr_infl_pre", 32'(bus.inflight), 32'h2);
        chk("mr_rv_pre", 32'(bus.rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_rv_async", 32'(bus.rsp_valid), 32'h0);
        chk("mr_infl_async", 32'(bus.inflight), 32'h0);
        chk("mr_ready_async", 32'(bus.req_ready), 32'h0);
        chk("mr_prod_async", 32'(bus.rsp_product), 32'h0);
        bus.req_valid = 4'h0;
        #1;
        rst_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            next_cycle();
            #1;
            chk($sformatf("mr_stale_rv_p%0d", p), 32'(bus.rsp_valid), 32'h0);
            chk($sformatf("mr_stale_infl_p%0d", p), 32'(bus.inflight), 32'h0);
        end
        bus.req_valid = 4'hF;
        #1;
        chk("mr_ptr0", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 4'h0;

        // two requesters, single-stage pipeline
        do_reset();
        bus2.req_a = {8'hC8, 8'h03};
        bus2.req_b = {8'h0A, 8'h05};
        for (int p = 0; p < 6; p++) begin
            next_cycle();
            bus2.req_valid = 2'b11;
            #1;
            chk($sformatf("l1_ready_p%0d", p), 32'(bus2.req_ready), (p % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("l1_rv_p%0d", p), 32'(bus2.rsp_valid), (p >= 1) ? 32'h1 : 32'h0);
            chk($sformatf("l1_infl_p%0d", p), 32'(bus2.inflight), (p >= 1) ? 32'h1 : 32'h0);
            if (p >= 1) begin
                chk($sformatf("l1_id_p%0d", p), 32'(bus2.rsp_id), 32'((p - 1) % 2));
                chk($sformatf("l1_prod_p%0d", p), 32'(bus2.rsp_product), 32'(d2_prod[(p - 1) % 2]));
            end
        end
        bus2.req_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- A_WIDTH, 8, operand A width
- B_WIDTH, 8, operand B width
- N_REQ, 4, number of requesters (2..8)
- LATENCY, 2, multiplier pipeline stages (1..4)
REQ-002 The block SHALL use one clock, `clk`; reset `rst_n` SHALL be asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock
- rst_n, in, 1, async active-low reset
- req_valid, in, N_REQ, per-requester request valid
- req_ready, out, N_REQ, per-requester accept (one-hot or zero)
- req_a, in, N_REQ*A_WIDTH, operand A, requester i at slice i
- req_b, in, N_REQ*B_WIDTH, operand B, requester i at slice i
- rsp_valid, out, 1, result valid
- rsp_ready, in, 1, result consumer ready
- rsp_id, out, clog2(N_REQ), requester index of result
- rsp_product, out, A_WIDTH+B_WIDTH, unsigned product
- inflight, out, clog2(LATENCY+1), number of valid pipeline stages

Function
REQ-004 The block SHALL share one unsigned A_WIDTH x B_WIDTH multiplier among N_REQ requesters; product width SHALL be A_WIDTH+B_WIDTH with no truncation.
REQ-005 The pipeline SHALL have LATENCY stages, each holding valid, id, and operand/product data; the last stage SHALL drive rsp_valid, rsp_id and rsp_product.
REQ-006 The advance signal SHALL be !rsp_valid || rsp_ready; all stages SHALL shift together only when advance=1, and SHALL hold otherwise.
REQ-007 Arbitration SHALL be round-robin with pointer ptr (reset 0): the grant SHALL go to the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod N_REQ.
REQ-008 req_ready[g] SHALL be 1 only when advance=1 and g is the granted index; all other req_ready bits SHALL be 0.
REQ-009 A transfer SHALL occur when req_valid[g] && req_ready[g]; on transfer, ptr SHALL become (g+1) mod N_REQ, otherwise ptr SHALL hold.
REQ-010 On advance with no transfer, a bubble (valid=0) SHALL enter stage 0.
REQ-011 With rsp_ready held 1, a request transferred at edge k SHALL appear on rsp_* after edge k+LATENCY-1, i.e. LATENCY cycles of latency, giving one result per cycle.
REQ-012 While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_id and rsp_product SHALL stay stable, and no new request SHALL be accepted.
REQ-013 A result SHALL be consumed on rsp_valid && rsp_ready; in the same cycle a new request SHALL be accepted, so the pipeline has no dead cycle.
REQ-014 inflight SHALL equal the count of valid stages and SHALL be registered: +1 on accept without consume, -1 on consume without accept, unchanged on both or neither.
REQ-015 req_ready SHALL depend combinationally only on req_valid, ptr, rsp_valid and rsp_ready, and SHALL NOT depend on operand values.
REQ-016 req_valid deasserted before transfer SHALL be legal; the grant SHALL then move to the next valid requester in the same cycle.
REQ-017 Stage data for invalid stages SHALL be don't-care; rsp_id and rsp_product SHALL be ignored by the consumer when rsp_valid=0.

Reset
REQ-018 While rst_n=0: all stage valids=0, rsp_valid=0, req_ready=0, ptr=0, inflight=0; rsp_id and rsp_product SHALL read 0.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight results immediately (asynchronously), with no result emitted after release.
REQ-020 After rst_n rises, the first grant SHALL be evaluable on the first clock edge.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (defaults unless stated):
- Single request: req_valid=4'b0001, a=8'hFF, b=8'hFF, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_product=16'hFE01, inflight peaks at 1.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,...; one result per cycle; rsp_id sequence matches.
- Backpressure: stream active, rsp_ready=0 for 5 cycles -> rsp_* frozen; req_ready=0; inflight=LATENCY; no loss or duplication after rsp_ready=1.
- Pointer wrap/skip: ptr=3 with only req 1 valid -> grant 1, then ptr=2; then req 0 and 2 valid -> grant 2.
- Mid-stream reset: rst_n low with inflight=2 -> rsp_valid=0 immediately; after release, inflight=0, ptr=0, and no stale result appears.
- Boundaries: a=0 or b=0 -> product 0; LATENCY=1 and N_REQ=2 build -> results 1 cycle after accept, with alternating grants.
